credit_return_fifo: RTL and testbench

- Receive-side terminator for fixed-latency pipelines whose valid strobe is carried by a delay line.
- Issues launch credits upstream and counts items in flight.
- Captures items when they emerge from the pipeline and presents them to a downstream ready/valid consumer.
- Guarantees that a pipeline with no stall capability never overruns the buffer, even while the consumer back-pressures.

---
 rtl/credit_return_fifo.sv | 140 ++++++++++++++
 tb/tb_credit_return_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_return_fifo.sv
// credit_return_fifo: receive-side terminator for a fixed-latency, non-stallable
// pipeline. It hands out launch credits, counts items in flight, captures items
// as they emerge and presents them to a ready/valid consumer. The buffer can
// never overrun because credits cover both stored and in-flight items.
module credit_return_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic          pipe_valid,
  input  logic [DW-1:0] pipe_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] occupancy,
  output logic [CW-1:0] inflight,
  output logic          err_overflow,
  output logic          err_orphan
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ONE_P     = PW'(1);

  logic [CW-1:0] occupancy_reg, occupancy_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          err_overflow_reg, err_overflow_next;
  logic          err_orphan_reg, err_orphan_next;

  logic [DW-1:0] mem_reg [DEPTH];

  logic [CW:0]   credit_sum;
  logic          launch;
  logic          ret_counted;
  logic          full;
  logic          wr_en;
  logic          pop;

  // Credit check and event decode; extra sum bit keeps the compare exact.
  always_comb begin
    credit_sum  = {1'b0, occupancy_reg} + {1'b0, inflight_reg};
    issue_ready = (credit_sum < DEPTH_SUM) && !rst;
    out_valid   = (occupancy_reg != '0);
    launch      = issue_valid && issue_ready;
    ret_counted = pipe_valid && (inflight_reg != '0);
    full        = (occupancy_reg == DEPTH_C);
    wr_en       = pipe_valid && !full;
    pop         = out_valid && out_ready;
  end

  // Next-state for counters, pointers and sticky error flags.
  always_comb begin
    inflight_next     = inflight_reg;
    occupancy_next    = occupancy_reg;
    rd_ptr_next       = rd_ptr_reg;
    wr_ptr_next       = wr_ptr_reg;
    err_overflow_next = err_overflow_reg;
    err_orphan_next   = err_orphan_reg;

    // A launch and a counted return in the same cycle cancel out.
    case ({launch, ret_counted})
      2'b10:   inflight_next = inflight_reg + ONE_C;
      2'b01:   inflight_next = inflight_reg - ONE_C;
      default: inflight_next = inflight_reg;
    endcase

    case ({wr_en, pop})
      2'b10:   occupancy_next = occupancy_reg + ONE_C;
      2'b01:   occupancy_next = occupancy_reg - ONE_C;
      default: occupancy_next = occupancy_reg;
    endcase

    if (wr_en) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + ONE_P;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + ONE_P;
    end

    // Full is judged on registered occupancy, so a pop in the same cycle
    // does not rescue an arriving item.
    if (pipe_valid && full) begin
      err_overflow_next = 1'b1;
    end
    if (pipe_valid && (inflight_reg == '0)) begin
      err_orphan_next = 1'b1;
    end
  end

  // State register; reset discards everything buffered or in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_reg    <= '0;
      inflight_reg     <= '0;
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      err_overflow_reg <= 1'b0;
      err_orphan_reg   <= 1'b0;
    end else begin
      occupancy_reg    <= occupancy_next;
      inflight_reg     <= inflight_next;
      rd_ptr_reg       <= rd_ptr_next;
      wr_ptr_reg       <= wr_ptr_next;
      err_overflow_reg <= err_overflow_next;
      err_orphan_reg   <= err_orphan_next;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg] <= pipe_data;
    end
  end

  // Head of buffer is read directly; no bypass from pipe_data.
  assign out_data     = mem_reg[rd_ptr_reg];
  assign occupancy    = occupancy_reg;
  assign inflight     = inflight_reg;
  assign err_overflow = err_overflow_reg;
  assign err_orphan   = err_orphan_reg;

  // Credits must cover every stored and in-flight item unless orphans
  // have already corrupted the accounting.
  credit_invariant: assert property (
    @(posedge clk) disable iff (rst)
    (!err_orphan_reg) |-> (credit_sum <= DEPTH_SUM)
  );

endmodule

// File: tb/tb_credit_return_fifo.sv
// Directed bench for credit_return_fifo with DEPTH=4 and a pipeline modelled
// as a 3-edge delay of the launch strobe carrying the launch index as data.
module tb_credit_return_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic          pipe_valid;
  logic [DW-1:0] pipe_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;
  logic          err_overflow;
  logic          err_orphan;

  logic          pipe_flush = 1'b1;
  logic          force_en = 1'b0;
  logic          force_valid = 1'b0;
  logic [7:0]    force_data = 8'h00;
  logic [2:0]    pv_sh = 3'b000;
  logic [7:0]    pd_sh [3];
  int            launch_idx = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int pops;

  credit_return_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .pipe_valid   (pipe_valid),
    .pipe_data    (pipe_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .inflight     (inflight),
    .err_overflow (err_overflow),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  // Pipeline model: a launch at edge t re-emerges at edge t+3.
  always @(posedge clk) begin
    if (pipe_flush) begin
      pv_sh      <= 3'b000;
      launch_idx <= 0;
      for (int i = 0; i < 3; i++) pd_sh[i] <= 8'h00;
    end else begin
      pv_sh    <= {pv_sh[1:0], issue_valid && issue_ready};
      pd_sh[0] <= 8'(launch_idx);
      pd_sh[1] <= pd_sh[0];
      pd_sh[2] <= pd_sh[1];
      if (issue_valid && issue_ready) launch_idx <= launch_idx + 1;
    end
  end

  assign pipe_valid = force_en ? force_valid : pv_sh[2];
  assign pipe_data  = force_en ? force_data  : pd_sh[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; pipe_flush = 1'b1;
    issue_valid = 1'b0; out_ready = 1'b0;
    force_en = 1'b0; force_valid = 1'b0; force_data = 8'h00;
    step(); step();
    rst = 1'b0; pipe_flush = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_issue_ready", 32'(issue_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_err_overflow", 32'(err_overflow), 32'd0);
    check("rst_err_orphan", 32'(err_orphan), 32'd0);
    rst = 1'b0; pipe_flush = 1'b0;
    #1;
    check("post_rst_issue_ready", 32'(issue_ready), 32'd1);

    // 1. Steady stream of 20 items, consumer always ready
    do_reset();
    issue_valid = 1'b1; out_ready = 1'b1; pops = 0;
    for (int cyc = 0; cyc < 300 && pops < 20; cyc++) begin
      if (launch_idx >= 20) issue_valid = 1'b0;
      if (cyc < 4) check("s1_issue_ready", 32'(issue_ready), 32'd1);
      if (out_valid) begin
        check("s1_data", 32'(out_data), 32'(pops));
        pops++;
      end
      step();
    end
    issue_valid = 1'b0;
    check("s1_pops", 32'(pops), 32'd20);
    check("s1_launches", 32'(launch_idx), 32'd20);
    check("s1_occupancy", 32'(occupancy), 32'd0);
    check("s1_inflight", 32'(inflight), 32'd0);
    check("s1_err_overflow", 32'(err_overflow), 32'd0);
    check("s1_err_orphan", 32'(err_orphan), 32'd0);

    // 2. Back-pressure: credits stop launches at 4, then drain
    do_reset();
    issue_valid = 1'b1; out_ready = 1'b0;
    repeat (4) step();
    check("s2_launches", 32'(launch_idx), 32'd4);
    check("s2_issue_ready_blocked", 32'(issue_ready), 32'd0);
    check("s2_occupancy_a", 32'(occupancy), 32'd1);
    check("s2_inflight_a", 32'(inflight), 32'd3);
    repeat (3) step();
    check("s2_launches_held", 32'(launch_idx), 32'd4);
    check("s2_occupancy_full", 32'(occupancy), 32'd4);
    check("s2_inflight_zero", 32'(inflight), 32'd0);
    check("s2_err_overflow", 32'(err_overflow), 32'd0);
    check("s2_issue_ready_full", 32'(issue_ready), 32'd0);
    check("s2_data_held", 32'(out_data), 32'd0);
    issue_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("s2_drain_valid", 32'(out_valid), 32'd1);
      check("s2_drain_data", 32'(out_data), 32'(k));
      step();
      check("s2_drain_occupancy", 32'(occupancy), 32'(3 - k));
      check("s2_drain_issue_ready", 32'(issue_ready), 32'd1);
    end
    check("s2_empty", 32'(out_valid), 32'd0);

    // 3. Launch, return and pop on the same edge; pointers wrap
    do_reset();
    issue_valid = 1'b1;
    step(); step();
    issue_valid = 1'b0;
    step(); step();
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    check("s3_occupancy_setup", 32'(occupancy), 32'd2);
    check("s3_inflight_setup", 32'(inflight), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(); step();
      check("s3_occupancy_hold", 32'(occupancy), 32'd2);
      check("s3_inflight_hold", 32'(inflight), 32'd1);
      issue_valid = 1'b1; out_ready = 1'b1;
      check("s3_head_before", 32'(out_data), 32'(k));
      step();
      issue_valid = 1'b0; out_ready = 1'b0;
      check("s3_occupancy_after", 32'(occupancy), 32'd2);
      check("s3_inflight_after", 32'(inflight), 32'd1);
      check("s3_head_after", 32'(out_data), 32'(k + 1));
      check("s3_launches", 32'(launch_idx), 32'(4 + k));
    end
    check("s3_err_overflow", 32'(err_overflow), 32'd0);
    check("s3_err_orphan", 32'(err_orphan), 32'd0);

    // 4. Orphan arrival right after reset
    do_reset();
    force_en = 1'b1; force_valid = 1'b1; force_data = 8'hA5;
    step();
    force_valid = 1'b0;
    check("s4_err_orphan", 32'(err_orphan), 32'd1);
    check("s4_inflight", 32'(inflight), 32'd0);
    check("s4_occupancy", 32'(occupancy), 32'd1);
    check("s4_out_valid", 32'(out_valid), 32'd1);
    check("s4_out_data", 32'(out_data), 32'hA5);
    check("s4_err_overflow", 32'(err_overflow), 32'd0);

    // 5. Overflow: five arrivals into a four-entry buffer
    do_reset();
    force_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      force_valid = 1'b1; force_data = 8'(16 + i);
      step();
      if (i == 3) begin
        check("s5_full_no_err", 32'(err_overflow), 32'd0);
        check("s5_full_occ", 32'(occupancy), 32'd4);
      end
    end
    force_valid = 1'b0;
    check("s5_occupancy", 32'(occupancy), 32'd4);
    check("s5_err_overflow", 32'(err_overflow), 32'd1);
    check("s5_head", 32'(out_data), 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("s5_drain_data", 32'(out_data), 32'(16 + i));
      step();
    end
    check("s5_drained", 32'(out_valid), 32'd0);

    // 6. Reset while items are in flight; survivors arrive as orphans
    do_reset();
    issue_valid = 1'b1; out_ready = 1'b0;
    repeat (3) step();
    check("s6_inflight_pre", 32'(inflight), 32'd3);
    check("s6_issue_ready_pre", 32'(issue_ready), 32'd1);
    rst = 1'b1; issue_valid = 1'b0;
    #1;
    check("s6_issue_ready_in_rst", 32'(issue_ready), 32'd0);
    step();
    check("s6_rst_occupancy", 32'(occupancy), 32'd0);
    check("s6_rst_inflight", 32'(inflight), 32'd0);
    check("s6_rst_out_valid", 32'(out_valid), 32'd0);
    check("s6_rst_err_orphan", 32'(err_orphan), 32'd0);
    check("s6_rst_issue_ready", 32'(issue_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("s6_issue_ready_release", 32'(issue_ready), 32'd1);
    step();
    check("s6_err_orphan", 32'(err_orphan), 32'd1);
    check("s6_occ_1", 32'(occupancy), 32'd1);
    check("s6_inflight", 32'(inflight), 32'd0);
    check("s6_head_1", 32'(out_data), 32'd1);
    step();
    check("s6_occ_2", 32'(occupancy), 32'd2);
    out_ready = 1'b1;
    step();
    check("s6_head_2", 32'(out_data), 32'd2);
    step();
    check("s6_empty", 32'(out_valid), 32'd0);
    check("s6_err_overflow", 32'(err_overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
